// File: rtl/microwave_pkg.sv
// Shared types and widths for the microwave oven control blocks.
package microwave_pkg;

   localparam int KEYPAD_W = 10;
   localparam int DIGIT_W  = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4,
      QLOAD = 3'd5
   } state_e;

   // Index of the highest set key; only meaningful for one-hot input.
   function automatic logic [DIGIT_W-1:0] key_to_bcd(input logic [KEYPAD_W-1:0] k);
      key_to_bcd = '0;
      for (int i = 0; i < KEYPAD_W; i++)
         if (k[i]) key_to_bcd = DIGIT_W'(i);
   endfunction

endpackage

// File: rtl/cook_sequencer_if.sv
// Panel-input and timer-control bundle between the panel, sequencer and timer.
interface cook_sequencer_if;
   import microwave_pkg::*;

   logic [KEYPAD_W-1:0] keypad;
   logic                start;
   logic                stop;
   logic                door_closed;
   logic                tick_1hz;
   logic                timer_zero;
   logic                load_strobe;
   logic [DIGIT_W-1:0]  load_digit;
   logic                timer_clear;
   logic                count_en;
   logic                mag_on;
   logic                beep;
   logic [2:0]          state;

   modport master (
      input  keypad, start, stop, door_closed, tick_1hz, timer_zero,
      output load_strobe, load_digit, timer_clear, count_en, mag_on, beep, state
   );

   modport slave (
      output keypad, start, stop, door_closed, tick_1hz, timer_zero,
      input  load_strobe, load_digit, timer_clear, count_en, mag_on, beep, state
   );

endinterface

// File: rtl/keypad_encoder.sv
// One-hot keypad to BCD with registered press detection; multi-key chords give no event.
module keypad_encoder
   import microwave_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [KEYPAD_W-1:0] keypad,
   output logic                key_evt,
   output logic [DIGIT_W-1:0]  key_digit
);

   logic any_q;
   logic any_now;

   assign any_now = |keypad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         any_q     <= 1'b0;
         key_evt   <= 1'b0;
         key_digit <= '0;
      end else begin
         any_q     <= any_now;
         key_evt   <= any_now & ~any_q & $onehot(keypad);
         key_digit <= key_to_bcd(keypad);
      end
   end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencing FSM: digit entry, cook/pause/done, magnetron and beeper.
// Optional quick start (fixed QUICK_SECS load from IDLE) enabled by `define QUICK_START_EN.
module cook_sequencer
   import microwave_pkg::*;
#(
   parameter int MAX_DIGITS = 3,
   parameter int BEEP_SECS  = 3,
   parameter int QUICK_SECS = 30
) (
   input logic              clk,
   input logic              reset,
   cook_sequencer_if.master bus
);

   localparam int BW = $clog2(BEEP_SECS + 1);

   state_e             state_q, state_d;
   logic [1:0]         digit_cnt_q, digit_cnt_d;
   logic [BW-1:0]      beep_cnt_q, beep_cnt_d;
   logic               load_strobe_q, load_strobe_d;
   logic [DIGIT_W-1:0] load_digit_q, load_digit_d;
   logic               timer_clear_q, timer_clear_d;
   logic               start_q, stop_q, start_evt, stop_evt;
   logic               key_evt;
   logic [DIGIT_W-1:0] key_digit;
   logic               can_start;
`ifdef QUICK_START_EN
   localparam logic [DIGIT_W-1:0] Q_TENS = DIGIT_W'(QUICK_SECS / 10);
   localparam logic [DIGIT_W-1:0] Q_ONES = DIGIT_W'(QUICK_SECS % 10);
   logic qstep_q, qstep_d, qdoor_q, qdoor_d;
`endif

   keypad_encoder u_keys (
      .clk      (clk),
      .reset    (reset),
      .keypad   (bus.keypad),
      .key_evt  (key_evt),
      .key_digit(key_digit)
   );

   assign can_start = start_evt & bus.door_closed & ~bus.timer_zero;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         digit_cnt_q   <= '0;
         beep_cnt_q    <= '0;
         load_strobe_q <= 1'b0;
         load_digit_q  <= '0;
         timer_clear_q <= 1'b0;
         start_q       <= 1'b0;
         stop_q        <= 1'b0;
         start_evt     <= 1'b0;
         stop_evt      <= 1'b0;
`ifdef QUICK_START_EN
         qstep_q       <= 1'b0;
         qdoor_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         digit_cnt_q   <= digit_cnt_d;
         beep_cnt_q    <= beep_cnt_d;
         load_strobe_q <= load_strobe_d;
         load_digit_q  <= load_digit_d;
         timer_clear_q <= timer_clear_d;
         start_q       <= bus.start;
         stop_q        <= bus.stop;
         start_evt     <= bus.start & ~start_q;
         stop_evt      <= bus.stop & ~stop_q;
`ifdef QUICK_START_EN
         qstep_q       <= qstep_d;
         qdoor_q       <= qdoor_d;
`endif
      end
   end

   // Every branch looks only at the current state, so a coincident event never
   // acts on the state being entered.
   always_comb begin
      state_d       = state_q;
      digit_cnt_d   = digit_cnt_q;
      beep_cnt_d    = beep_cnt_q;
      load_strobe_d = 1'b0;
      load_digit_d  = '0;
      timer_clear_d = 1'b0;
`ifdef QUICK_START_EN
      qstep_d       = qstep_q;
      qdoor_d       = qdoor_q;
`endif
      case (state_q)
         IDLE: begin
            if (stop_evt) timer_clear_d = 1'b1;
            else if (key_evt) begin
               load_strobe_d = 1'b1;
               load_digit_d  = key_digit;
               digit_cnt_d   = 2'd1;
               state_d       = ENTRY;
            end
`ifdef QUICK_START_EN
            else if (start_evt && bus.door_closed) begin
               load_strobe_d = 1'b1;
               load_digit_d  = Q_TENS;
               qstep_d       = 1'b0;
               qdoor_d       = 1'b0;
               state_d       = QLOAD;
            end
`endif
         end
         ENTRY: begin
            if (stop_evt) begin
               timer_clear_d = 1'b1;
               digit_cnt_d   = '0;
               state_d       = IDLE;
            end else if (can_start) state_d = COOK;
            else if (key_evt && digit_cnt_q < 2'(MAX_DIGITS)) begin
               load_strobe_d = 1'b1;
               load_digit_d  = key_digit;
               digit_cnt_d   = digit_cnt_q + 2'd1;
            end
         end
         COOK: begin
            if (!bus.door_closed) state_d = PAUSE;
            else if (bus.timer_zero) begin
               digit_cnt_d = '0;
               state_d     = DONE;
            end else if (stop_evt) state_d = PAUSE;
         end
         PAUSE: begin
            if (stop_evt) begin
               timer_clear_d = 1'b1;
               digit_cnt_d   = '0;
               state_d       = IDLE;
            end else if (can_start) state_d = COOK;
         end
         DONE: begin
            if (key_evt || start_evt || stop_evt) begin
               beep_cnt_d = '0;
               state_d    = IDLE;
            end else if (bus.tick_1hz) begin
               if (beep_cnt_q == BW'(BEEP_SECS - 1)) begin
                  beep_cnt_d = '0;
                  state_d    = IDLE;
               end else beep_cnt_d = beep_cnt_q + 1'b1;
            end
         end
`ifdef QUICK_START_EN
         QLOAD: begin
            // Door opening anywhere in the two-load window diverts to PAUSE.
            qdoor_d = qdoor_q | ~bus.door_closed;
            if (!qstep_q) begin
               load_strobe_d = 1'b1;
               load_digit_d  = Q_ONES;
               qstep_d       = 1'b1;
            end else state_d = qdoor_d ? PAUSE : COOK;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign bus.load_strobe = load_strobe_q;
   assign bus.load_digit  = load_digit_q;
   assign bus.timer_clear = timer_clear_q;
   assign bus.count_en    = (state_q == COOK);
   assign bus.mag_on      = (state_q == COOK) & bus.door_closed;
   assign bus.beep        = (state_q == DONE);
   assign bus.state       = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed test-plan scenarios then random panel activity vs an event model.
module tb_cook_sequencer;

   localparam int MAX_DIGITS = 3;
   localparam int BEEP_SECS  = 3;
   localparam int QUICK_SECS = 30;
   localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4, S_QLOAD = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cook_sequencer_if bus();

   cook_sequencer #(.MAX_DIGITS(MAX_DIGITS), .BEEP_SECS(BEEP_SECS), .QUICK_SECS(QUICK_SECS)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int total = 0, bad = 0;
   int nloads = 0, nclears = 0;

   // Model: state, digit count, beep seconds, events seen at the previous edge.
   int ms, mdig, mbeep, mq, pdig, e_digit;
   bit mqdoor, prev_any, prev_st, prev_sp, pk, pst, psp, e_strobe, e_clear;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      ms = S_IDLE; mdig = 0; mbeep = 0; mq = 0; mqdoor = 0;
      prev_any = 0; prev_st = 0; prev_sp = 0; pk = 0; pst = 0; psp = 0; pdig = 0;
      e_strobe = 0; e_clear = 0; e_digit = 0;
   endtask

   task automatic load(input int d);
      e_strobe = 1; e_digit = d;
   endtask

   task automatic model_edge();
      bit door, zero, tick, go;
      int n;
      door = bus.door_closed; zero = bus.timer_zero; tick = bus.tick_1hz;
      go = pst && door && !zero;
      e_strobe = 0; e_clear = 0; e_digit = 0;
      case (ms)
         S_IDLE:
            if (psp) e_clear = 1;
            else if (pk) begin load(pdig); mdig = 1; ms = S_ENTRY; end
`ifdef QUICK_START_EN
            else if (pst && door) begin load(QUICK_SECS / 10); mq = 0; mqdoor = 0; ms = S_QLOAD; end
`endif
         S_ENTRY:
            if (psp) begin e_clear = 1; mdig = 0; ms = S_IDLE; end
            else if (go) ms = S_COOK;
            else if (pk && mdig < MAX_DIGITS) begin load(pdig); mdig++; end
         S_COOK:
            if (!door) ms = S_PAUSE;
            else if (zero) begin mdig = 0; ms = S_DONE; end
            else if (psp) ms = S_PAUSE;
         S_PAUSE:
            if (psp) begin e_clear = 1; mdig = 0; ms = S_IDLE; end
            else if (go) ms = S_COOK;
         S_DONE:
            if (pk || pst || psp) begin mbeep = 0; ms = S_IDLE; end
            else if (tick) begin
               mbeep++;
               if (mbeep == BEEP_SECS) begin mbeep = 0; ms = S_IDLE; end
            end
         S_QLOAD: begin
            mqdoor = mqdoor || !door;
            if (mq == 0) begin load(QUICK_SECS % 10); mq = 1; end
            else ms = mqdoor ? S_PAUSE : S_COOK;
         end
         default: ms = S_IDLE;
      endcase
      n = $countones(bus.keypad);
      pk = (n == 1) && !prev_any;
      for (int i = 0; i < 10; i++) if (bus.keypad[i]) pdig = i;
      prev_any = (n != 0);
      pst = bus.start && !prev_st; prev_st = bus.start;
      psp = bus.stop && !prev_sp;  prev_sp = bus.stop;
   endtask

   task automatic check_all();
      if (bus.load_strobe) nloads++;
      if (bus.timer_clear) nclears++;
      chk("state", int'(bus.state), ms);
      chk("load_strobe", int'(bus.load_strobe), int'(e_strobe));
      chk("load_digit", int'(bus.load_digit), e_digit);
      chk("timer_clear", int'(bus.timer_clear), int'(e_clear));
      chk("count_en", int'(bus.count_en), int'(ms == S_COOK));
      chk("mag_on", int'(bus.mag_on), int'(ms == S_COOK && bus.door_closed));
      chk("beep", int'(bus.beep), int'(ms == S_DONE));
   endtask

   task automatic cycle();
      #1 chk("mag_comb", int'(bus.mag_on), int'(ms == S_COOK && bus.door_closed));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic press(input int k);
      bus.keypad = 10'(1 << k); cycles(2);
      bus.keypad = '0;          cycle();
   endtask

   task automatic pulse_start();
      bus.start = 1'b1; cycle();
      bus.start = 1'b0; cycles(2);
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1; cycle();
      bus.stop = 1'b0; cycles(2);
   endtask

   task automatic tick();
      bus.tick_1hz = 1'b1; cycle();
      bus.tick_1hz = 1'b0; cycles(2);
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      #1;
      chk("rst_state", int'(bus.state), 0);
      chk("rst_count_en", int'(bus.count_en), 0);
      chk("rst_mag_on", int'(bus.mag_on), 0);
      chk("rst_beep", int'(bus.beep), 0);
      chk("rst_strobe", int'(bus.load_strobe), 0);
      chk("rst_clear", int'(bus.timer_clear), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int r;
      bus.keypad = '0; bus.start = 0; bus.stop = 0; bus.door_closed = 1;
      bus.tick_1hz = 0; bus.timer_zero = 0;
      model_reset();
      @(negedge clk);
      reset_dut();
      check_all();

      // Entry: fourth digit beyond MAX_DIGITS is dropped
      nloads = 0;
      press(1); press(3); press(0); press(5);
      chk("entry_loads", nloads, 3);
      pulse_start();
      chk("cook_state", int'(bus.state), S_COOK);
      chk("cook_mag", int'(bus.mag_on), 1);

      // Door interlock then resume without reload
      bus.door_closed = 1'b0; cycle();
      chk("pause_on_door", int'(bus.state), S_PAUSE);
      bus.door_closed = 1'b1; cycle();
      pulse_start();
      chk("resume", int'(bus.state), S_COOK);
      chk("no_reload", nloads, 3);

      // Completion and beep duration
      bus.timer_zero = 1'b1; cycle();
      bus.timer_zero = 1'b0;
      chk("done", int'(bus.state), S_DONE);
      tick(); tick();
      chk("still_beep", int'(bus.beep), 1);
      tick();
      chk("beep_end", int'(bus.beep), 0);
      chk("idle_after_done", int'(bus.state), S_IDLE);

      // Stop semantics
      press(2); pulse_start();
      nclears = 0;
      pulse_stop();
      chk("stop_pause", int'(bus.state), S_PAUSE);
      pulse_stop();
      chk("stop_idle", int'(bus.state), S_IDLE);
      chk("stop_clear", nclears, 1);

      // Guards: door open, timer zero, two-key chord
      press(4);
      bus.door_closed = 1'b0; pulse_start();
      chk("start_door_open", int'(bus.state), S_ENTRY);
      bus.door_closed = 1'b1; bus.timer_zero = 1'b1; cycle();
      pulse_start();
      chk("start_zero", int'(bus.state), S_ENTRY);
      bus.timer_zero = 1'b0; cycle();
      nloads = 0;
      bus.keypad = 10'h005; cycles(2);
      bus.keypad = '0; cycle();
      chk("chord_ignored", nloads, 0);
      pulse_stop();

      // Reset mid-cook
      press(7); pulse_start();
      chk("cook_before_reset", int'(bus.state), S_COOK);
      reset_dut();
      check_all();

      nloads = 0;
      pulse_start();
      cycle();
`ifdef QUICK_START_EN
      chk("quick_loads", nloads, 2);
      chk("quick_cook", int'(bus.state), S_COOK);
      pulse_stop(); pulse_stop();
`else
      chk("idle_start_ignored", int'(bus.state), S_IDLE);
`endif

      // Random panel activity, at most one input change per cycle
      for (int c = 0; c < 4000; c++) begin
         bus.tick_1hz = 1'b0;
         r = $urandom_range(0, 23);
         case (r)
            0, 1, 2:    bus.keypad = 10'(1 << $urandom_range(0, 9));
            3:          bus.keypad = ($urandom_range(0, 1) == 0) ? 10'h005 : 10'h300;
            4, 5, 6:    bus.keypad = '0;
            7:          bus.start = 1'b1;
            8, 9:       bus.start = 1'b0;
            10:         bus.stop = ($urandom_range(0, 2) == 0);
            11:         bus.stop = 1'b0;
            12:         bus.door_closed = ~bus.door_closed;
            13:         bus.door_closed = 1'b1;
            14:         bus.timer_zero = ($urandom_range(0, 3) == 0);
            15, 16, 17: bus.tick_1hz = 1'b1;
            default: ;
         endcase
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
- Central sequencing FSM for the microwave oven.
- Accepts keypad digits and start/stop/door events, and drives the minutes/seconds counter's load, clear and count-enable controls.
- Owns magnetron enable and the end-of-cook beeper.
- Sits between raw panel inputs and the timer datapath, replacing scattered per-block control.

Parameters:
- MAX_DIGITS, 3, maximum digits accepted per entry (M:SS); further keys ignored.
- BEEP_SECS, 3, number of tick_1hz pulses beep stays high in DONE.
- QUICK_SECS, 30, seconds loaded by quick start (used only with QUICK_START_EN); two BCD digits, tens then ones.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- keypad  in  10  synchronized key levels, bit k = digit k.
- start  in  1  synchronized level; rising edge is an event.
- stop  in  1  synchronized level; rising edge is an event.
- door_closed  in  1  synchronized level, 1 = closed.
- tick_1hz  in  1  single-cycle pulse, once per second.
- timer_zero  in  1  counter reads 0:00.
- load_strobe  out  1  one-cycle pulse; counter shifts in load_digit.
- load_digit  out  4  BCD digit, valid with load_strobe.
- timer_clear  out  1  one-cycle pulse; counter clears to 0:00.
- count_en  out  1  counter decrements on tick_1hz while high.
- mag_on  out  1  magnetron enable.
- beep  out  1  buzzer enable.
- state  out  3  current state encoding, for debug and display.

Behaviour:
- Reset: state=IDLE. All outputs 0. digit_cnt=0, beep_cnt=0. Edge-detect history registers = 0, so a key held through reset yields one press after release.
- Key event: OR(keypad) rises at sample edge N, with exactly one keypad bit set. Multi-bit patterns are ignored with no event.
- Start/stop events: registered rising-edge detection on start and stop.
- Event response: all event responses (strobes, transitions) are registered and appear at edge N+1.
- Encoding: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4, QLOAD=5.
- Moore outputs: count_en = (state==COOK). mag_on = (state==COOK) & door_closed; the door gating is combinational, so mag_on drops the same cycle the door opens. beep = (state==DONE).
- IDLE:
  - Key event -> load_strobe=1, load_digit=key, digit_cnt=1, go ENTRY.
  - Stop event -> timer_clear pulse.
  - Start event ignored.
- ENTRY:
  - Key event with digit_cnt<MAX_DIGITS -> load pulse, digit_cnt++. At MAX_DIGITS, keys are ignored.
  - Stop event -> timer_clear, digit_cnt=0, go IDLE.
  - Start event with door_closed & !timer_zero -> COOK. Otherwise start is ignored.
- COOK (priority: door open > timer_zero > stop):
  - !door_closed -> PAUSE.
  - timer_zero -> DONE, digit_cnt=0.
  - Stop event -> PAUSE.
  - Keys ignored.
- PAUSE:
  - Start event with door_closed & !timer_zero -> COOK.
  - Stop event -> timer_clear, digit_cnt=0, go IDLE.
  - Keys ignored.
- DONE:
  - beep_cnt increments on tick_1hz; when it reaches BEEP_SECS -> IDLE, beep_cnt=0.
  - Any key, start or stop event -> IDLE immediately, beep_cnt=0; the key is not loaded.
- Simultaneity: an event coinciding with a transition is evaluated in the pre-transition state only.
- Widths: digit_cnt is 2 bits and saturates. beep_cnt is sized $clog2(BEEP_SECS+1).

Optional Feature:
- Macro: QUICK_START_EN.
- Defined:
  - Start event in IDLE with door_closed -> load QUICK_SECS tens digit at N+1 (state QLOAD), ones digit at N+2, then COOK at N+3.
  - If the door opens during QLOAD, go to PAUSE after both loads.
- Undefined: QLOAD does not exist, and start in IDLE is ignored.

Decomposition:
- Package microwave_pkg:
  - State enum/localparams.
  - KEYPAD_W=10, DIGIT_W=4.
  - Priority-order constants.
- Sub-module keypad_encoder:
  - Converts 10-bit one-hot to BCD digit plus valid.
  - Performs registered rising-edge detection.
  - Outputs key_evt and key_digit.

Test Plan:
- Entry and cook: press 1, 3, 0, 5 → three load_strobes with digits 1,3,0; the fourth key is ignored. Start with door closed → COOK, count_en=1, mag_on=1.
- Door interlock: door_closed=0 mid-COOK → mag_on=0 the same cycle, PAUSE next edge. Close door, then start → COOK resumes with no reload.
- Completion: timer_zero=1 in COOK → DONE, beep=1 for exactly 3 tick_1hz pulses, then IDLE with beep=0.
- Stop semantics: stop in COOK → PAUSE; second stop → timer_clear pulse, IDLE, digit_cnt=0.
- Guards: start with door open in ENTRY is ignored. Start with timer_zero=1 is ignored. keypad=0x005 (two keys) → no load.
- Reset mid-COOK: assert reset → all outputs 0 immediately. Then run with QUICK_START_EN: start from IDLE → loads 3 then 0, then COOK.
